// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_ctrl_pkg : shared constants and FSM encoding for the UART TX arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
package uart_ctrl_pkg;

   localparam int UART_DATA_W = 7;
   localparam int BAUD_TICKS  = 521;
   localparam int FRAME_BITS  = 11;

   typedef enum logic [2:0] {
      ST_RST_WAIT = 3'd0,
      ST_IDLE     = 3'd1,
      ST_START    = 3'd2,
      ST_HOLD     = 3'd3,
      ST_GAP      = 3'd4
   } arb_state_t;

   // Index width that stays legal even for a single requester.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if : requester bus plus UART TX drive signals
// Revision 1.0
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = UART_DATA_W
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ack;
   logic                      tx_start;
   logic [DATA_W-1:0]         datain_tx;
   logic [ID_W-1:0]           grant_id;
   logic                      busy;

   modport master (
      output req_valid, req_data,
      input  req_ack, tx_start, datain_tx, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data,
      output req_ack, tx_start, datain_tx, grant_id, busy
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick starting after the last grant
// Revision 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any_req
);

   always_comb begin : p_pick
      logic            found;
      int              cand;
      logic [ID_W-1:0] cand_id;
      gnt     = '0;
      idx     = last;
      any_req = |req;
      found   = 1'b0;
      cand    = 0;
      cand_id = '0;
      // Scan last+1 .. last+NUM_REQ so the previous winner is checked last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand    = (int'(last) + k) % NUM_REQ;
         cand_id = ID_W'(cand);
         if (!found && req[cand_id]) begin
            found        = 1'b1;
            gnt[cand_id] = 1'b1;
            idx          = cand_id;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_arbiter : round-robin share of one 7-bit UART TX, frame-timed hold
// Revision 1.0
// ----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_ctrl_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int DATA_W       = UART_DATA_W,
   parameter int FRAME_CYCLES = FRAME_BITS * BAUD_TICKS,
   parameter int GAP_CYCLES   = BAUD_TICKS,
   parameter int CNT_W        = 13
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_arbiter_if.slave    bus
);

   localparam int ID_W = id_width(NUM_REQ);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   =
      (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_chk_num_req
      $error("uart_tx_arbiter: NUM_REQ must be 2..8");
   end
   if (DATA_W != UART_DATA_W) begin : g_chk_data_w
      $error("uart_tx_arbiter: DATA_W must match the UART character width");
   end
   if (FRAME_CYCLES < 1 || FRAME_CYCLES >= (1 << CNT_W) ||
       GAP_CYCLES < 0 || GAP_CYCLES >= (1 << CNT_W)) begin : g_chk_cnt_w
      $error("uart_tx_arbiter: CNT_W too narrow for FRAME_CYCLES/GAP_CYCLES");
   end

   logic [DATA_W-1:0] chars [NUM_REQ];
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_chars
      assign chars[i] = bus.req_data[i*DATA_W +: DATA_W];
   end

   logic [NUM_REQ-1:0] arb_gnt;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;

   arb_state_t         state_q,     state_d;
   logic [CNT_W-1:0]   count_q,     count_d;
   logic [NUM_REQ-1:0] req_ack_q,   req_ack_d;
   logic               tx_start_q,  tx_start_d;
   logic [DATA_W-1:0]  datain_tx_q, datain_tx_d;
   logic [ID_W-1:0]    grant_id_q,  grant_id_d;
   logic               busy_q,      busy_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req     (bus.req_valid),
      .last    (grant_id_q),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .any_req (arb_any)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      req_ack_d   = '0;
      tx_start_d  = 1'b0;
      datain_tx_d = datain_tx_q;
      grant_id_d  = grant_id_q;
      case (state_q)
         ST_RST_WAIT: begin
            // Lets a frame the UART had in flight across our reset drain out.
            if (count_q == FRAME_LAST) begin
               count_d = '0;
               state_d = ST_IDLE;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         ST_IDLE: begin
            if (arb_any) begin
               datain_tx_d = chars[arb_idx];
               grant_id_d  = arb_idx;
               req_ack_d   = arb_gnt;
               tx_start_d  = 1'b1;
               count_d     = '0;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (count_q == FRAME_LAST) begin
               count_d = '0;
               state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         ST_GAP: begin
            if (count_q == GAP_LAST) begin
               count_d = '0;
               state_d = ST_IDLE;
            end else begin
               count_d = count_q + CNT_ONE;
            end
         end
         default: begin
            count_d = '0;
            state_d = ST_RST_WAIT;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RST_WAIT;
         count_q     <= '0;
         req_ack_q   <= '0;
         tx_start_q  <= 1'b0;
         datain_tx_q <= '0;
         grant_id_q  <= ID_W'(NUM_REQ - 1);
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         req_ack_q   <= req_ack_d;
         tx_start_q  <= tx_start_d;
         datain_tx_q <= datain_tx_d;
         grant_id_q  <= grant_id_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ack   = req_ack_q;
   assign bus.tx_start  = tx_start_q;
   assign bus.datain_tx = datain_tx_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter : directed checks of arbitration, timing, hold and reset
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
   import uart_ctrl_pkg::*;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   int   gap2_cnt;

   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(7)) bus  ();
   uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(7)) bus2 ();

   uart_tx_arbiter #(
      .NUM_REQ(4), .DATA_W(7), .FRAME_CYCLES(20), .GAP_CYCLES(3), .CNT_W(13)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   uart_tx_arbiter #(
      .NUM_REQ(4), .DATA_W(7), .FRAME_CYCLES(20), .GAP_CYCLES(0), .CNT_W(13)
   ) dut_g0 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dut_g0.state_q == ST_GAP) gap2_cnt <= gap2_cnt + 1;
   end

   // A requester may only drop req_valid in the cycle its ack is showing.
   logic [3:0] vprev;
   always @(posedge clk) begin
      if (!rst) begin
         assert (((vprev & ~bus.req_valid) & ~bus.req_ack) == 4'b0)
            else $error("protocol violation: req_valid dropped before req_ack");
      end
      vprev <= bus.req_valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_start(input bit sel, input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(sel ? bus2.tx_start : bus.tx_start) && n < limit);
   endtask

   initial begin
      int n;
      int bad;
      n_total  = 0;
      n_bad    = 0;
      gap2_cnt = 0;
      rst = 1'b1;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus2.req_valid = '0;
      bus2.req_data  = '0;
      repeat (3) tick();

      check_eq("rst_busy",  32'(bus.busy), 32'd1);
      check_eq("rst_start", 32'(bus.tx_start), 32'd0);
      check_eq("rst_ack",   32'(bus.req_ack), 32'd0);
      check_eq("rst_data",  32'(bus.datain_tx), 32'd0);
      check_eq("rst_gid",   32'(bus.grant_id), 32'd3);

      // T1: request raised at reset release waits out RST_WAIT
      rst = 1'b0;
      bus.req_valid = 4'b0001;
      bus.req_data[0 +: 7] = 7'h41;
      wait_start(0, 40, n);
      check_eq("t1_latency", 32'(n), 32'd21);
      check_eq("t1_ack",  32'(bus.req_ack), 32'b0001);
      check_eq("t1_data", 32'(bus.datain_tx), 32'h41);
      check_eq("t1_gid",  32'(bus.grant_id), 32'd0);
      bus.req_valid = 4'b0000;
      bad = 0;
      for (int i = 0; i < 23; i++) begin
         tick();
         if (bus.busy !== 1'b1 || bus.datain_tx !== 7'h41 || bus.tx_start !== 1'b0) bad++;
      end
      check_eq("t1_hold_gap_bad", 32'(bad), 32'd0);
      tick();
      check_eq("t1_idle_busy", 32'(bus.busy), 32'd0);

      // T5: reset in the middle of HOLD
      bus.req_valid = 4'b0010;
      bus.req_data[7 +: 7] = 7'h22;
      wait_start(0, 5, n);
      check_eq("t5_latency", 32'(n), 32'd1);
      check_eq("t5_gid", 32'(bus.grant_id), 32'd1);
      bus.req_valid = 4'b0000;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      check_eq("t5_busy",  32'(bus.busy), 32'd1);
      check_eq("t5_start", 32'(bus.tx_start), 32'd0);
      check_eq("t5_ack",   32'(bus.req_ack), 32'd0);
      check_eq("t5_data",  32'(bus.datain_tx), 32'd0);
      check_eq("t5_gid",   32'(bus.grant_id), 32'd3);

      // T2: all four requesters, served 0..3 with 25-cycle spacing
      rst = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_data  = {7'h13, 7'h12, 7'h11, 7'h10};
      wait_start(0, 40, n);
      check_eq("t5_no_start_in_wait", 32'(n), 32'd21);
      for (int k = 0; k < 4; k++) begin
         check_eq("t2_gid",  32'(bus.grant_id), 32'(k));
         check_eq("t2_ack",  32'(bus.req_ack), 32'(1 << k));
         check_eq("t2_data", 32'(bus.datain_tx), 32'(8'h10 + k));
         bus.req_valid[k] = 1'b0;
         if (k < 3) begin
            wait_start(0, 40, n);
            check_eq("t2_spacing", 32'(n), 32'd25);
         end
      end

      // T3: serve 2, then 1 and 3 pending -> 3 before 1
      bus.req_valid[2] = 1'b1;
      bus.req_data[14 +: 7] = 7'h32;
      wait_start(0, 40, n);
      check_eq("t3_spacing2", 32'(n), 32'd25);
      check_eq("t3_gid2",  32'(bus.grant_id), 32'd2);
      check_eq("t3_data2", 32'(bus.datain_tx), 32'h32);
      bus.req_valid = 4'b1010;
      bus.req_data[7 +: 7]  = 7'h31;
      bus.req_data[21 +: 7] = 7'h33;
      wait_start(0, 40, n);
      check_eq("t3_gid3",  32'(bus.grant_id), 32'd3);
      check_eq("t3_data3", 32'(bus.datain_tx), 32'h33);
      bus.req_valid[3] = 1'b0;
      wait_start(0, 40, n);
      check_eq("t3_gid1",  32'(bus.grant_id), 32'd1);
      check_eq("t3_data1", 32'(bus.datain_tx), 32'h31);
      bus.req_valid[1] = 1'b0;

      // T4: data change after ack must not reach datain_tx
      bus.req_valid[0] = 1'b1;
      bus.req_data[0 +: 7] = 7'h55;
      wait_start(0, 40, n);
      check_eq("t4_gid", 32'(bus.grant_id), 32'd0);
      check_eq("t4_ack", 32'(bus.req_ack), 32'b0001);
      bus.req_valid[0] = 1'b0;
      tick();
      bus.req_data[0 +: 7] = 7'h2A;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) tick();
         if (bus.datain_tx !== 7'h55) bad++;
      end
      check_eq("t4_hold_bad", 32'(bad), 32'd0);
      check_eq("t4_data_end", 32'(bus.datain_tx), 32'h55);
      repeat (4) tick();
      check_eq("t4_idle_busy", 32'(bus.busy), 32'd0);

      // T6: zero-gap build, back-to-back frames 22 cycles apart
      bus2.req_valid = 4'b0011;
      bus2.req_data[0 +: 7] = 7'h05;
      bus2.req_data[7 +: 7] = 7'h06;
      wait_start(1, 10, n);
      check_eq("t6_latency", 32'(n), 32'd1);
      check_eq("t6_gid0",  32'(bus2.grant_id), 32'd0);
      check_eq("t6_data0", 32'(bus2.datain_tx), 32'h05);
      bus2.req_valid[0] = 1'b0;
      wait_start(1, 40, n);
      check_eq("t6_spacing", 32'(n), 32'd22);
      check_eq("t6_gid1",  32'(bus2.grant_id), 32'd1);
      check_eq("t6_data1", 32'(bus2.datain_tx), 32'h06);
      bus2.req_valid[1] = 1'b0;
      repeat (21) tick();
      check_eq("t6_idle_busy", 32'(bus2.busy), 32'd0);
      check_eq("t6_gap_visits", 32'(gap2_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
